// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time into a word-organised RAM,
// with fixed wait states, byte/half/word lanes, load extension and error flagging.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] w_data_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic        busy_o,
  output logic        ack_o,
  output logic [31:0] r_data_o,
  output logic        err_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic        capture_s, access_s;

  logic        we_r, unsigned_r;
  logic [31:0] addr_r, w_data_r;
  logic [1:0]  size_r;

  logic        ack_r, err_r;
  logic [31:0] r_data_r;

  logic [31:0] mem_r [0:DEPTH-1];

  logic        sel_in_s;
  logic        a_we_s, a_uns_s;
  logic [31:0] a_addr_s, a_wdata_s;
  logic [1:0]  a_size_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic        illegal_s;
  logic [31:0] rd_word_s, load_s;
  logic        wr_en_s;
  logic [3:0]  wr_be_s;
  logic [31:0] wr_data_s;

  function automatic logic access_illegal(input logic [1:0] size, input logic [31:0] addr);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr[0];
      2'b10:   bad = |addr[1:0];
      default: bad = 1'b1;
    endcase
    return bad | (|(addr >> (DEPTH_LOG2 + 2)));
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [31:0] sh;
    logic [31:0] ext;
    sh = word >> {lane, 3'b000};
    case (size)
      2'b00:   ext = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   ext = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: ext = sh;
    endcase
    return ext;
  endfunction

  function automatic logic [3:0] store_lanes(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // With zero wait states the access happens on the capture edge, so use the live inputs.
  assign sel_in_s   = (state_r == ST_IDLE);
  assign a_we_s     = sel_in_s ? we_i       : we_r;
  assign a_uns_s    = sel_in_s ? unsigned_i : unsigned_r;
  assign a_addr_s   = sel_in_s ? addr_i     : addr_r;
  assign a_wdata_s  = sel_in_s ? w_data_i   : w_data_r;
  assign a_size_s   = sel_in_s ? size_i     : size_r;

  assign idx_s      = a_addr_s[DEPTH_LOG2+1:2];
  assign illegal_s  = access_illegal(a_size_s, a_addr_s);
  assign rd_word_s  = mem_r[idx_s];
  assign load_s     = load_extend(rd_word_s, a_size_s, a_addr_s[1:0], a_uns_s);
  assign wr_en_s    = access_s & a_we_s & ~illegal_s & rst_i;
  assign wr_be_s    = store_lanes(a_size_s, a_addr_s[1:0]);
  assign wr_data_s  = store_data(a_size_s, a_wdata_s);

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    capture_s   = 1'b0;
    access_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_i) begin
          capture_s = 1'b1;
          if (WAIT_CYCLES == 0) begin
            access_s    = 1'b1;
            state_nxt_s = ST_RESP;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = WAIT_INIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          access_s    = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, captured request and registered response.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      we_r       <= 1'b0;
      unsigned_r <= 1'b0;
      addr_r     <= 32'h0000_0000;
      w_data_r   <= 32'h0000_0000;
      size_r     <= 2'b00;
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
      r_data_r   <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (capture_s) begin
        we_r       <= we_i;
        unsigned_r <= unsigned_i;
        addr_r     <= addr_i;
        w_data_r   <= w_data_i;
        size_r     <= size_i;
      end
      if (access_s) begin
        ack_r    <= 1'b1;
        err_r    <= illegal_s;
        r_data_r <= (illegal_s || a_we_s) ? 32'h0000_0000 : load_s;
      end else begin
        ack_r <= 1'b0;
        err_r <= 1'b0;
      end
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be_s[i]) mem_r[idx_s][i*8 +: 8] <= wr_data_s[i*8 +: 8];
      end
    end
  end

  assign busy_o   = (state_r != ST_IDLE);
  assign ack_o    = ack_r;
  assign err_o    = err_r;
  assign r_data_o = r_data_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: byte-level memory model with
// edge-count timing, directed literal checks and a randomized phase.
module tb_dmem_responder;
  localparam int W = 1;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] w_data_i = 32'h0;
  logic [1:0]  size_i = 2'b00;
  logic        unsigned_i = 1'b0;
  logic        busy_o, ack_o, err_o;
  logic [31:0] r_data_o;

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .w_data_i(w_data_i), .size_i(size_i), .unsigned_i(unsigned_i),
    .busy_o(busy_o), .ack_o(ack_o), .r_data_o(r_data_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mem_b [0:4095];
  int          cyc = 0;
  bit          started = 0;
  bit          pending = 0;
  int          ack_edge = 0;
  int          free_edge = 0;
  logic        p_we, p_uns;
  logic [31:0] p_addr, p_wd;
  logic [1:0]  p_size;
  logic        exp_ack = 0, exp_err = 0, exp_busy = 0;
  logic [31:0] exp_rd = 32'h0;

  task automatic model_access();
    int nb;
    logic [31:0] v;
    bit illegal;
    nb = (p_size == 2'd0) ? 1 : (p_size == 2'd1) ? 2 : 4;
    illegal = (p_size == 2'd3) || (p_size == 2'd1 && p_addr[0]) ||
              (p_size == 2'd2 && p_addr[1:0] != 2'd0) || (p_addr >= 32'h1000);
    exp_ack = 1'b1;
    if (illegal) begin
      exp_err = 1'b1;
      exp_rd  = 32'h0;
    end else if (p_we) begin
      for (int i = 0; i < nb; i++) mem_b[p_addr[11:0] + 12'(i)] = p_wd[8*i +: 8];
      exp_rd = 32'h0;
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(mem_b[p_addr[11:0] + 12'(i)]) << (8*i));
      if (!p_uns && nb == 1) v = {{24{v[7]}}, v[7:0]};
      if (!p_uns && nb == 2) v = {{16{v[15]}}, v[15:0]};
      exp_rd = v;
    end
  endtask

  always @(posedge clk_i) begin
    cyc++;
    started = 1;
    if (!rst_i) begin
      pending = 0;
      free_edge = cyc + 1;
      exp_ack = 0; exp_err = 0; exp_rd = 32'h0;
    end else begin
      exp_ack = 0; exp_err = 0;
      if (!pending && cyc >= free_edge && req_i) begin
        p_we = we_i; p_uns = unsigned_i; p_addr = addr_i; p_wd = w_data_i; p_size = size_i;
        pending = 1;
        ack_edge = cyc + W;
        free_edge = cyc + W + 2;
      end
      if (pending && cyc == ack_edge) begin
        model_access();
        pending = 0;
      end
    end
    exp_busy = (cyc + 1 < free_edge);
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_i) begin
    if (started) begin
      chk("ack", {31'h0, ack_o}, {31'h0, exp_ack});
      chk("busy", {31'h0, busy_o}, {31'h0, exp_busy});
      chk("err", {31'h0, err_o}, {31'h0, exp_err});
      chk("rdata", r_data_o, exp_rd);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] size, input logic uns,
                        output logic [31:0] rd, output logic err, output int lat);
    req_i = 1'b1; we_i = we; addr_i = addr; w_data_i = wd; size_i = size; unsigned_i = uns;
    @(negedge clk_i);
    req_i = 1'b0;
    lat = 1;
    while (!ack_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    if (!ack_o) begin
      bad++; total++;
      $display("FAIL ack_timeout: no ack for addr %h after %0d cycles", addr, lat);
    end
    rd = r_data_o;
    err = err_o;
    @(negedge clk_i);
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  int          acks;

  initial begin
    // Reset held with a pending request.
    rst_i = 1'b0; req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0; w_data_i = 32'h1122_3344;
    size_i = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("rst_ack", {31'h0, ack_o}, 32'h0);
      chk("rst_busy", {31'h0, busy_o}, 32'h0);
      chk("rst_rdata", r_data_o, 32'h0);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("first_capture_busy", {31'h0, busy_o}, 32'h1);
    req_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // Fill words 1..15 with a known pattern.
    for (int k = 1; k < 16; k++) begin
      do_req(1'b1, 32'(4*k), 32'hA500_0000 | 32'(k), 2'b10, 1'b0, rd, err, lat);
    end

    do_req(1'b1, 32'h010, 32'hDEAD_BEEF, 2'b10, 1'b0, rd, err, lat);
    chk("st_word_lat", 32'(lat), 32'd2);
    chk("st_word_err", {31'h0, err}, 32'h0);
    do_req(1'b0, 32'h010, 32'h0, 2'b10, 1'b0, rd, err, lat);
    chk("ld_word", rd, 32'hDEAD_BEEF);

    do_req(1'b1, 32'h013, 32'h0000_0080, 2'b00, 1'b0, rd, err, lat);
    do_req(1'b0, 32'h013, 32'h0, 2'b00, 1'b0, rd, err, lat);
    chk("ld_byte_s", rd, 32'hFFFF_FF80);
    do_req(1'b0, 32'h013, 32'h0, 2'b00, 1'b1, rd, err, lat);
    chk("ld_byte_u", rd, 32'h0000_0080);
    do_req(1'b0, 32'h012, 32'h0, 2'b01, 1'b0, rd, err, lat);
    chk("ld_half_s", rd, 32'hFFFF_80AD);
    do_req(1'b0, 32'h010, 32'h0, 2'b10, 1'b0, rd, err, lat);
    chk("ld_word_merged", rd, 32'h80AD_BEEF);

    do_req(1'b0, 32'h011, 32'h0, 2'b01, 1'b0, rd, err, lat);
    chk("err_half_mis", {rd[30:0], err}, 32'h1);
    do_req(1'b0, 32'h012, 32'h0, 2'b10, 1'b0, rd, err, lat);
    chk("err_word_mis", {rd[30:0], err}, 32'h1);
    do_req(1'b0, 32'h000, 32'h0, 2'b11, 1'b0, rd, err, lat);
    chk("err_size", {rd[30:0], err}, 32'h1);
    do_req(1'b1, 32'h1000, 32'hCAFE_F00D, 2'b10, 1'b0, rd, err, lat);
    chk("err_range", {rd[30:0], err}, 32'h1);
    do_req(1'b0, 32'h000, 32'h0, 2'b10, 1'b0, rd, err, lat);
    chk("word0_intact", rd, 32'h1122_3344);
    chk("word0_err", {31'h0, err}, 32'h0);

    // Continuous request: one capture every W+2 cycles.
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0; size_i = 2'b10;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (ack_o) acks++;
    end
    chk("handshake_acks", 32'(acks), 32'd4);
    req_i = 1'b0;
    repeat (4) @(negedge clk_i);

    // Reset during WAIT abandons the store.
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h020; w_data_i = 32'h1234_5678; size_i = 2'b10;
    @(negedge clk_i);
    req_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    chk("midrst_ack", {31'h0, ack_o}, 32'h0);
    chk("midrst_busy", {31'h0, busy_o}, 32'h0);
    repeat (3) @(negedge clk_i);
    do_req(1'b0, 32'h020, 32'h0, 2'b10, 1'b0, rd, err, lat);
    chk("midrst_keep", rd, 32'hA500_0008);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 800; i++) begin
      rst_i      = ($urandom_range(0, 99) != 0);
      req_i      = $urandom_range(0, 1);
      we_i       = $urandom_range(0, 1);
      unsigned_i = $urandom_range(0, 1);
      w_data_i   = $urandom;
      size_i     = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr_i     = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (size_i == 2'b01) addr_i[0] = 1'b0;
        if (size_i == 2'b10) addr_i[1:0] = 2'b00;
      end
      if ($urandom_range(0, 15) == 0) addr_i = 32'h1000 + 32'($urandom_range(0, 255));
      @(negedge clk_i);
    end
    rst_i = 1'b1;
    req_i = 1'b0;
    repeat (5) @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
